// File: rtl/vm_change_dispenser.sv
// vm_change_dispenser
//
// Breaks one change value per transaction into single-coin eject requests to four coin
// hoppers. Hopper 0 holds the largest denomination and hopper 3 the smallest. Each pass
// chooses the largest denomination that still fits the remaining value. Hoppers flagged
// empty are skipped. A transaction ends with a one-cycle o_done pulse, and o_short reports
// any value that could not be paid.
//
// Optional feature: define VM_ACK_TIMEOUT_EN to bound the wait for i_eject_ack. A hopper
// that does not ack within ACK_TIMEOUT cycles is masked for the rest of the transaction.
//
// Ports
//   i_clk           clock
//   i_rst           synchronous reset, active-high
//   i_change_valid  1-cycle strobe; i_change_value is a new request (accepted only in IDLE)
//   i_change_value  change to pay out
//   i_hopper_empty  bit k set: hopper k is empty and is never selected
//   i_eject_ack     hopper driver has ejected the requested coin
//   o_eject_req     request one coin from hopper o_eject_denom
//   o_eject_denom   hopper index 0..3, stable while o_eject_req is high
//   o_busy          high in every state except IDLE
//   o_done          1-cycle pulse at end of transaction
//   o_short         payout incomplete; valid with o_done, held until next accept
//   o_remaining     value still owed
//   o_state         FSM state: IDLE=0 SELECT=1 EJECT=2 GAP=3 DONE=4
module vm_change_dispenser #(
    parameter int unsigned VALUE_W     = 7,
    parameter int unsigned DEN0        = 20,
    parameter int unsigned DEN1        = 10,
    parameter int unsigned DEN2        = 5,
    parameter int unsigned DEN3        = 1,
    parameter int unsigned GAP_CYCLES  = 4,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_change_valid,
    input  logic [VALUE_W-1:0] i_change_value,
    input  logic [3:0]         i_hopper_empty,
    input  logic               i_eject_ack,
    output logic               o_eject_req,
    output logic [1:0]         o_eject_denom,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_short,
    output logic [VALUE_W-1:0] o_remaining,
    output logic [2:0]         o_state
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StSelect = 3'd1,
        StEject  = 3'd2,
        StGap    = 3'd3,
        StDone   = 3'd4
    } state_e;

    // One counter serves both the GAP delay and the ack timeout; they never overlap.
    localparam int unsigned CntMax = (GAP_CYCLES > ACK_TIMEOUT) ? GAP_CYCLES : ACK_TIMEOUT;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    state_e             state_q, state_d;
    logic [VALUE_W-1:0] remaining_q, remaining_d;
    logic [1:0]         denom_q, denom_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               short_q, short_d;
    logic               req_q, req_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic [3:0]         mask;
    logic               sel_found;
    logic [1:0]         sel_idx;

`ifdef VM_ACK_TIMEOUT_EN
    logic [3:0] mask_q, mask_d;
    assign mask = mask_q;
`else
    assign mask = 4'b0000;
`endif

    function automatic logic [VALUE_W-1:0] den_of(input logic [1:0] k);
        logic [VALUE_W-1:0] v;
        unique case (k)
            2'd0:    v = VALUE_W'(DEN0);
            2'd1:    v = VALUE_W'(DEN1);
            2'd2:    v = VALUE_W'(DEN2);
            default: v = VALUE_W'(DEN3);
        endcase
        return v;
    endfunction

    // Scan from smallest to largest so the lowest eligible index (largest coin) wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if ((den_of(2'(k)) <= remaining_q) && !i_hopper_empty[k] && !mask[k]) begin
                sel_found = 1'b1;
                sel_idx   = 2'(k);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        denom_d     = denom_q;
        cnt_d       = cnt_q;
        short_d     = short_q;
`ifdef VM_ACK_TIMEOUT_EN
        mask_d      = mask_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (i_change_valid) begin
                    remaining_d = i_change_value;
                    short_d     = 1'b0;
`ifdef VM_ACK_TIMEOUT_EN
                    mask_d      = 4'b0000;
`endif
                    state_d     = StSelect;
                end
            end
            StSelect: begin
                if (remaining_q == '0) begin
                    state_d = StDone;
                end else if (sel_found) begin
                    denom_d = sel_idx;
                    cnt_d   = '0;
                    state_d = StEject;
                end else begin
                    // Short is decided here so it is already valid alongside o_done.
                    short_d = 1'b1;
                    state_d = StDone;
                end
            end
            StEject: begin
                if (i_eject_ack) begin
                    // Cannot underflow: the hopper was chosen with den <= remaining.
                    remaining_d = remaining_q - den_of(denom_q);
                    cnt_d       = CntW'(GAP_CYCLES - 1);
                    state_d     = StGap;
                end
`ifdef VM_ACK_TIMEOUT_EN
                else if (cnt_q == CntW'(ACK_TIMEOUT - 1)) begin
                    mask_d[denom_q] = 1'b1;
                    cnt_d           = CntW'(GAP_CYCLES - 1);
                    state_d         = StGap;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            StGap: begin
                if (cnt_q == '0) begin
                    state_d = StSelect;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are registered from the next state so they line up with o_state.
        req_d  = (state_d == StEject);
        done_d = (state_d == StDone);
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            denom_q     <= 2'd0;
            cnt_q       <= '0;
            short_q     <= 1'b0;
            req_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
`ifdef VM_ACK_TIMEOUT_EN
            mask_q      <= 4'b0000;
`endif
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            denom_q     <= denom_d;
            cnt_q       <= cnt_d;
            short_q     <= short_d;
            req_q       <= req_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
`ifdef VM_ACK_TIMEOUT_EN
            mask_q      <= mask_d;
`endif
        end
    end

    assign o_eject_req   = req_q;
    assign o_eject_denom = denom_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_short       = short_q;
    assign o_remaining   = remaining_q;
    assign o_state       = state_q;

endmodule

// File: tb/tb_vm_change_dispenser.sv
// Directed bench for vm_change_dispenser: 20/10/5/1 hoppers, 4-cycle gap between coins.
module tb_vm_change_dispenser;

`ifdef VM_ACK_TIMEOUT_EN
    localparam int unsigned TbAckTimeout = 8;
`else
    localparam int unsigned TbAckTimeout = 255;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       change_valid;
    logic [6:0] change_value;
    logic [3:0] hopper_empty;
    logic       eject_ack;
    logic       eject_req;
    logic [1:0] eject_denom;
    logic       busy;
    logic       done;
    logic       short_flag;
    logic [6:0] remaining;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    vm_change_dispenser #(
        .VALUE_W    (7),
        .DEN0       (20),
        .DEN1       (10),
        .DEN2       (5),
        .DEN3       (1),
        .GAP_CYCLES (4),
        .ACK_TIMEOUT(TbAckTimeout)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_change_valid(change_valid),
        .i_change_value(change_value),
        .i_hopper_empty(hopper_empty),
        .i_eject_ack   (eject_ack),
        .o_eject_req   (eject_req),
        .o_eject_denom (eject_denom),
        .o_busy        (busy),
        .o_done        (done),
        .o_short       (short_flag),
        .o_remaining   (remaining),
        .o_state       (state)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [6:0] value);
        change_valid = 1'b1;
        change_value = value;
        step();
        change_valid = 1'b0;
    endtask

    // Wait for a request, check it, ack it in its first cycle, check the new remaining.
    task automatic eject_one(input string tag, input logic [1:0] denom, input int exp_wait,
                             input int rem_after);
        int n    = 0;
        bit seen = 1'b0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            step();
            if (eject_req) begin
                seen = 1'b1;
                n    = i;
            end
        end
        check({tag, " req_seen"}, 32'(seen), 1);
        if (seen) begin
            check({tag, " wait"}, n, exp_wait);
            check({tag, " denom"}, eject_denom, denom);
            check({tag, " state"}, state, 2);
            eject_ack = 1'b1;
            step();
            eject_ack = 1'b0;
            check({tag, " req_drop"}, eject_req, 0);
            check({tag, " remaining"}, remaining, rem_after);
        end
    endtask

    // Wait for o_done (no request may appear meanwhile), then check the return to IDLE.
    task automatic wait_done(input string tag, input int exp_wait, input logic exp_short,
                             input int exp_rem);
        int n       = 0;
        bit seen    = 1'b0;
        bit saw_req = 1'b0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            step();
            if (eject_req) saw_req = 1'b1;
            if (done) begin
                seen = 1'b1;
                n    = i;
            end
        end
        check({tag, " done_seen"}, 32'(seen), 1);
        check({tag, " no_req"}, 32'(saw_req), 0);
        if (seen) begin
            check({tag, " done_wait"}, n, exp_wait);
            check({tag, " short"}, short_flag, exp_short);
            check({tag, " remaining"}, remaining, exp_rem);
            check({tag, " state_done"}, state, 4);
            check({tag, " busy_done"}, busy, 1);
            step();
            check({tag, " done_pulse"}, done, 0);
            check({tag, " state_idle"}, state, 0);
            check({tag, " busy_idle"}, busy, 0);
            check({tag, " short_held"}, short_flag, exp_short);
            check({tag, " rem_held"}, remaining, exp_rem);
        end
    endtask

    initial begin
        bit saw_done;
        bit dropped;
        int n;

        rst          = 1'b1;
        change_valid = 1'b0;
        change_value = '0;
        hopper_empty = 4'b0000;
        eject_ack    = 1'b0;
        step();
        step();
        check("rst req", eject_req, 0);
        check("rst denom", eject_denom, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst short", short_flag, 0);
        check("rst remaining", remaining, 0);
        check("rst state", state, 0);
        rst = 1'b0;

        // Stray ack in IDLE does nothing.
        eject_ack = 1'b1;
        step();
        eject_ack = 1'b0;
        check("idle_ack state", state, 0);
        check("idle_ack remaining", remaining, 0);

        // 35 = 20 + 10 + 5
        accept(7'd35);
        check("t1 state_select", state, 1);
        check("t1 busy", busy, 1);
        check("t1 latched", remaining, 35);
        eject_one("t1 c1", 2'd0, 1, 15);
        eject_one("t1 c2", 2'd1, 5, 5);
        eject_one("t1 c3", 2'd2, 5, 0);
        wait_done("t1", 5, 1'b0, 0);

        // Zero change: straight to DONE.
        accept(7'd0);
        wait_done("t2", 1, 1'b0, 0);

        // 40 with the 20 hopper empty: four 10s.
        hopper_empty = 4'b0001;
        accept(7'd40);
        eject_one("t3 c1", 2'd1, 1, 30);
        eject_one("t3 c2", 2'd1, 5, 20);
        eject_one("t3 c3", 2'd1, 5, 10);
        eject_one("t3 c4", 2'd1, 5, 0);
        wait_done("t3", 5, 1'b0, 0);

        // 7 with the 1 hopper empty: one 5, then short by 2.
        hopper_empty = 4'b1000;
        accept(7'd7);
        eject_one("t4 c1", 2'd2, 1, 2);
        wait_done("t4", 5, 1'b1, 2);

        // Second request during EJECT is ignored; reset aborts without o_done.
        hopper_empty = 4'b0000;
        accept(7'd13);
        check("t5 short_cleared", short_flag, 0);
        step();
        check("t5 req", eject_req, 1);
        check("t5 denom", eject_denom, 1);
        change_valid = 1'b1;
        change_value = 7'd99;
        step();
        change_valid = 1'b0;
        check("t5 ignored_rem", remaining, 13);
        check("t5 ignored_state", state, 2);
        check("t5 ignored_req", eject_req, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5 rst_req", eject_req, 0);
        check("t5 rst_state", state, 0);
        check("t5 rst_done", done, 0);
        check("t5 rst_busy", busy, 0);
        check("t5 rst_remaining", remaining, 0);
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done) saw_done = 1'b1;
        end
        check("t5 no_done", 32'(saw_done), 0);
        check("t5 stays_idle", state, 0);

`ifdef VM_ACK_TIMEOUT_EN
        // Hopper 0 never acks: request lasts 8 cycles, then 20 is paid as two 10s.
        accept(7'd20);
        step();
        check("t6 req", eject_req, 1);
        check("t6 denom", eject_denom, 0);
        dropped = 1'b0;
        n       = 0;
        for (int i = 1; i <= 40 && !dropped; i++) begin
            step();
            if (!eject_req) begin
                dropped = 1'b1;
                n       = i;
            end
        end
        check("t6 dropped", 32'(dropped), 1);
        check("t6 timeout_len", n, 8);
        check("t6 rem_kept", remaining, 20);
        eject_one("t6 c1", 2'd1, 5, 10);
        eject_one("t6 c2", 2'd1, 5, 0);
        wait_done("t6", 5, 1'b0, 0);
`else
        dropped = 1'b0;
        n       = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
